// File: rtl/conv3x3_stream.sv
// conv3x3_stream: 3x3 Sobel/passthrough convolution on a raster pixel stream.
// Ports: iCLK/iRST clock and async reset; iDATA/iDVAL/iSOF/iMODE input
// stream, mode latched on iSOF; oDATA/oDVAL/oSOF result stream (3 cycles).
// Optional CONV3X3_THRESH_EN adds iTHRESH (latched on iSOF) and binarises.
module conv3x3_stream #(
    parameter int DATA_W = 12,
    parameter int LINE_W = 640
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic              iSOF,
    input  logic [1:0]        iMODE,
`ifdef CONV3X3_THRESH_EN
    input  logic [DATA_W-1:0] iTHRESH,
`endif
    output logic [DATA_W-1:0] oDATA,
    output logic              oDVAL,
    output logic              oSOF
);

    localparam int XW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam int SW = DATA_W + 4;
    localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
    localparam logic [SW-1:0] PIX_MAX = {4'b0000, {DATA_W{1'b1}}};

    logic [XW-1:0]     x_q, x_eff;
    logic [1:0]        y_q, y_eff;
    logic [1:0]        mode_q, mode_eff;
    logic [DATA_W-1:0] lb1 [LINE_W];
    logic [DATA_W-1:0] lb2 [LINE_W];
    logic [DATA_W-1:0] lb1_rd, lb2_rd;
    logic [DATA_W-1:0] p [3][3];

    logic              v1, b1, s1;
    logic [1:0]        m1;
    logic signed [SW-1:0] gx_d, gy_d, gx2, gy2;
    logic [DATA_W-1:0] c2;
    logic              v2, b2, s2;
    logic [1:0]        m2;
    logic [SW-1:0]     ax, ay, res;
    logic [DATA_W-1:0] sat, out_d;

`ifdef CONV3X3_THRESH_EN
    logic [DATA_W-1:0] thr_q, thr_eff, t1, t2;
`endif

    function automatic logic signed [SW-1:0] ext(input logic [DATA_W-1:0] v);
        return $signed({4'b0000, v});
    endfunction

    // iSOF forces the pixel accepted in the same cycle to (0,0)
    // and selects the new mode for it.
    always_comb begin
        x_eff    = iSOF ? '0 : x_q;
        y_eff    = iSOF ? '0 : y_q;
        mode_eff = iSOF ? iMODE : mode_q;
        lb1_rd   = lb1[x_eff];
        lb2_rd   = lb2[x_eff];
    end

`ifdef CONV3X3_THRESH_EN
    assign thr_eff = iSOF ? iTHRESH : thr_q;
`endif

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            x_q    <= '0;
            y_q    <= '0;
            mode_q <= '0;
        end else begin
            if (iSOF)
                mode_q <= iMODE;
            if (iDVAL) begin
                if (x_eff == X_LAST) begin
                    x_q <= '0;
                    y_q <= (y_eff == 2'd2) ? 2'd2 : y_eff + 2'd1;
                end else begin
                    x_q <= x_eff + XW'(1);
                    y_q <= y_eff;
                end
            end else if (iSOF) begin
                x_q <= '0;
                y_q <= '0;
            end
        end
    end

`ifdef CONV3X3_THRESH_EN
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            thr_q <= '0;
            t1    <= '0;
            t2    <= '0;
        end else begin
            if (iSOF)
                thr_q <= iTHRESH;
            t1 <= thr_eff;
            t2 <= t1;
        end
    end
`endif

    // Line buffers and window are never cleared; the border flag
    // masks anything stale.
    always_ff @(posedge iCLK) begin
        if (iDVAL) begin
            lb1[x_eff] <= iDATA;
            lb2[x_eff] <= lb1_rd;
            for (int r = 0; r < 3; r++) begin
                p[r][0] <= p[r][1];
                p[r][1] <= p[r][2];
            end
            p[0][2] <= lb2_rd;
            p[1][2] <= lb1_rd;
            p[2][2] <= iDATA;
        end
    end

    always_comb begin
        gx_d = (ext(p[0][2]) + ext(p[1][2]) + ext(p[1][2]) + ext(p[2][2]))
             - (ext(p[0][0]) + ext(p[1][0]) + ext(p[1][0]) + ext(p[2][0]));
        gy_d = (ext(p[2][0]) + ext(p[2][1]) + ext(p[2][1]) + ext(p[2][2]))
             - (ext(p[0][0]) + ext(p[0][1]) + ext(p[0][1]) + ext(p[0][2]));
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            v1    <= 1'b0;
            b1    <= 1'b1;
            s1    <= 1'b0;
            m1    <= '0;
            v2    <= 1'b0;
            b2    <= 1'b1;
            s2    <= 1'b0;
            m2    <= '0;
            gx2   <= '0;
            gy2   <= '0;
            c2    <= '0;
            oDVAL <= 1'b0;
            oSOF  <= 1'b0;
            oDATA <= '0;
        end else begin
            v1  <= iDVAL;
            b1  <= (x_eff < XW'(2)) || (y_eff < 2'd2);
            s1  <= iSOF;
            m1  <= mode_eff;
            v2  <= v1;
            b2  <= b1;
            s2  <= s1;
            m2  <= m1;
            gx2 <= gx_d;
            gy2 <= gy_d;
            c2  <= p[1][1];
            oDVAL <= v2;
            oSOF  <= s2;
            if (v2)
                oDATA <= out_d;
        end
    end

    always_comb begin
        ax  = gx2[SW-1] ? $unsigned(-gx2) : $unsigned(gx2);
        ay  = gy2[SW-1] ? $unsigned(-gy2) : $unsigned(gy2);
        res = '0;
        case (m2)
            2'd0: res = {4'b0000, c2};
            2'd1: res = ax;
            2'd2: res = ay;
            2'd3: res = ax + ay;
        endcase
        sat = (res > PIX_MAX) ? PIX_MAX[DATA_W-1:0] : res[DATA_W-1:0];
`ifdef CONV3X3_THRESH_EN
        out_d = b2 ? '0 : ((sat >= t2) ? '1 : '0);
`else
        out_d = b2 ? '0 : sat;
`endif
    end

endmodule

// File: tb/tb_conv3x3_stream.sv
// tb_conv3x3_stream: table-driven frames plus hand sequences for
// SOF/line-end collision and mid-frame reset, checked against an image model.
module tb_conv3x3_stream;

    localparam int DW = 12;
    localparam int LW = 8;
    localparam int FLAT = 0, VSTEP = 1, HSTEP = 2, RAND = 3;

    logic          iCLK = 1'b0;
    logic          iRST = 1'b1;
    logic [DW-1:0] iDATA = '0;
    logic          iDVAL = 1'b0;
    logic          iSOF = 1'b0;
    logic [1:0]    iMODE = '0;
    logic [DW-1:0] oDATA;
    logic          oDVAL;
    logic          oSOF;
`ifdef CONV3X3_THRESH_EN
    logic [DW-1:0] iTHRESH = '0;
    int            m_thr = 0;
`endif

    conv3x3_stream #(.DATA_W(DW), .LINE_W(LW)) dut (
        .iCLK(iCLK),
        .iRST(iRST),
        .iDATA(iDATA),
        .iDVAL(iDVAL),
        .iSOF(iSOF),
        .iMODE(iMODE),
`ifdef CONV3X3_THRESH_EN
        .iTHRESH(iTHRESH),
`endif
        .oDATA(oDATA),
        .oDVAL(oDVAL),
        .oSOF(oSOF)
    );

    always #5 iCLK = ~iCLK;

    typedef struct {
        logic [1:0] mode;
        int         pat;
        bit         gap;
        int         rows;
        int         spot;
    } vec_t;

    typedef struct {
        int exp;
        int spot;
    } sb_t;

    sb_t  sbq[$];
    int   img[0:31][0:LW-1];
    int   mx = 0, my = 0, m_mode = 0;
    int   spot_val = -1;
    bit   hdv[3];
    bit   hsof[3];
    int   nvec = 0, nerr = 0;
    vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pix(input int pat, input int x, input int y);
        case (pat)
            FLAT:    return 100;
            VSTEP:   return (x < 4) ? 0 : 1200;
            HSTEP:   return (y < 3) ? 0 : 1200;
            default: return int'($urandom_range(0, 4095));
        endcase
    endfunction

    function automatic int model(input int x, input int y);
        int w[3][3];
        int gx, gy, r;
        if (x < 2 || y < 2)
            return 0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[i][j] = img[y-2+i][x-2+j];
        gx = (w[0][2] + 2*w[1][2] + w[2][2]) - (w[0][0] + 2*w[1][0] + w[2][0]);
        gy = (w[2][0] + 2*w[2][1] + w[2][2]) - (w[0][0] + 2*w[0][1] + w[0][2]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        case (m_mode)
            0:       r = w[1][1];
            1:       r = gx;
            2:       r = gy;
            default: r = gx + gy;
        endcase
        if (r > 4095) r = 4095;
`ifdef CONV3X3_THRESH_EN
        r = (r >= m_thr) ? 4095 : 0;
`endif
        return r;
    endfunction

    task automatic check_outputs();
        sb_t e;
        chk("odval", int'(oDVAL), int'(hdv[2]));
        chk("osof", int'(oSOF), int'(hsof[2]));
        if (iRST)
            chk("rst_odata", int'(oDATA), 0);
        if (oDVAL) begin
            if (sbq.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("odata", int'(oDATA), e.exp);
                if (e.spot >= 0)
                    chk("spot", int'(oDATA), e.spot);
            end
        end
    endtask

    task automatic cycle(input bit rst, input bit dv, input int d,
                         input bit sof, input logic [1:0] md);
        sb_t e;
        @(negedge iCLK);
        check_outputs();
        if (rst && !iRST) begin
            iRST = 1'b1;
            #1;
            chk("rst_now_odval", int'(oDVAL), 0);
            chk("rst_now_osof", int'(oSOF), 0);
            chk("rst_now_odata", int'(oDATA), 0);
        end
        iRST  = rst;
        iDVAL = rst ? 1'($urandom) : dv;
        iDATA = rst ? DW'($urandom) : DW'(d);
        iSOF  = rst ? 1'($urandom) : sof;
        iMODE = sof ? md : 2'($urandom);
`ifdef CONV3X3_THRESH_EN
        iTHRESH = sof ? DW'(2000) : DW'($urandom);
`endif
        hdv[2]  = hdv[1];
        hdv[1]  = hdv[0];
        hsof[2] = hsof[1];
        hsof[1] = hsof[0];
        if (rst) begin
            hdv     = '{default: 1'b0};
            hsof    = '{default: 1'b0};
            sbq.delete();
            mx      = 0;
            my      = 0;
            m_mode  = 0;
`ifdef CONV3X3_THRESH_EN
            m_thr   = 0;
`endif
        end else begin
            hdv[0]  = dv;
            hsof[0] = sof;
            if (sof) begin
                mx     = 0;
                my     = 0;
                m_mode = int'(md);
`ifdef CONV3X3_THRESH_EN
                m_thr  = 2000;
`endif
            end
            if (dv) begin
                img[my][mx] = d;
                e.exp  = model(mx, my);
                e.spot = (mx == 4 && my == 3) ? spot_val : -1;
                sbq.push_back(e);
                mx++;
                if (mx == LW) begin
                    mx = 0;
                    if (my < 31) my++;
                end
            end
        end
    endtask

    task automatic run_frame(input vec_t v);
        spot_val = v.spot;
`ifdef CONV3X3_THRESH_EN
        if (v.spot >= 0)
            spot_val = (v.spot >= 2000) ? 4095 : 0;
`endif
        for (int y = 0; y < v.rows; y++)
            for (int x = 0; x < LW; x++) begin
                cycle(0, 1, pix(v.pat, x, y), (x == 0 && y == 0), v.mode);
                if (v.gap)
                    cycle(0, 0, int'($urandom_range(0, 4095)), 0, 2'd0);
            end
        spot_val = -1;
    endtask

    initial begin
        vecs[0]  = '{2'd0, FLAT,  1'b0, 5, 100};
        vecs[1]  = '{2'd3, FLAT,  1'b0, 5, 0};
        vecs[2]  = '{2'd1, VSTEP, 1'b0, 5, 4095};
        vecs[3]  = '{2'd2, VSTEP, 1'b0, 5, 0};
        vecs[4]  = '{2'd3, VSTEP, 1'b0, 5, 4095};
        vecs[5]  = '{2'd1, VSTEP, 1'b1, 5, 4095};
        vecs[6]  = '{2'd3, VSTEP, 1'b1, 4, 4095};
        vecs[7]  = '{2'd2, HSTEP, 1'b0, 6, 4095};
        vecs[8]  = '{2'd1, RAND,  1'b0, 5, -1};
        vecs[9]  = '{2'd2, RAND,  1'b1, 5, -1};
        vecs[10] = '{2'd3, RAND,  1'b0, 6, -1};
        vecs[11] = '{2'd0, RAND,  1'b0, 4, -1};
        hdv  = '{default: 1'b0};
        hsof = '{default: 1'b0};

        // reset held with random inputs, then a lone iSOF
        for (int i = 0; i < 6; i++)
            cycle(1, 0, 0, 0, 2'd0);
        cycle(0, 0, 0, 1, 2'd0);
        for (int i = 0; i < 4; i++)
            cycle(0, 0, 0, 0, 2'd0);

        foreach (vecs[i])
            run_frame(vecs[i]);

        // iSOF on the last pixel of a line: that pixel is (0,0), mode 1
        for (int i = 0; i < LW * 3; i++)
            cycle(0, 1, pix(RAND, 0, 0), (i == 0 || i == LW*3-1),
                  (i == LW*3-1) ? 2'd1 : 2'd3);
        for (int i = 0; i < LW * 4 - 1; i++)
            cycle(0, 1, pix(RAND, 0, 0), 0, 2'd0);

        // reset pulse at row 3 column 5 of a step frame
        for (int y = 0; y < 7; y++)
            for (int x = 0; x < LW; x++) begin
                if (y == 3 && x == 5)
                    cycle(1, 0, 0, 0, 2'd0);
                cycle(0, 1, pix(VSTEP, x, y), (x == 0 && y == 0), 2'd3);
            end

        run_frame(vecs[4]);
        for (int i = 0; i < 6; i++)
            cycle(0, 0, 0, 0, 2'd0);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
